// File: rtl/adc_channel_scheduler_pkg.sv
// Shared state encoding and ADS1115 config-register field constants for the
// ADC channel scheduler.
package adc_channel_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_GAP      = 3'd3,
    ST_PAUSED   = 3'd4
  } state_e;

  localparam logic [2:0] MUX_SE_BASE = 3'b100;
  localparam logic       OS_START    = 1'b1;
  localparam logic       MODE_SINGLE = 1'b1;
  localparam logic [2:0] DEFAULT_PGA = 3'b010;

  // Config MSB: OS | MUX[2:0] | PGA[2:0] | MODE, MUX selecting AINx vs GND.
  function automatic logic [7:0] cfg_msb(input logic [1:0] ch, input logic [2:0] pga);
    logic [2:0] mux;
    mux = MUX_SE_BASE | {1'b0, ch};
    return {OS_START, mux, pga, MODE_SINGLE};
  endfunction

endpackage

// File: rtl/adc_channel_scheduler_rr_picker.sv
// Combinational round-robin search: first enabled channel strictly after the
// last served index, wrapping at NUM_CH.
module adc_rr_picker
  import adc_channel_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [1:0]        ptr_i,
  output logic [1:0]        idx_o,
  output logic              found_o
);

  int   best_dist_s;
  int   dist_s;
  logic take_s;

  // Pick the enabled channel with the smallest forward distance from ptr_i.
  always_comb begin
    best_dist_s = NUM_CH;
    dist_s      = 0;
    take_s      = 1'b0;
    idx_o       = 2'd0;
    found_o     = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      dist_s      = j - int'(ptr_i) - 1;
      dist_s      = (dist_s < 0) ? dist_s + NUM_CH : dist_s;
      take_s      = mask_i[j] && (dist_s < best_dist_s);
      best_dist_s = take_s ? dist_s : best_dist_s;
      idx_o       = take_s ? 2'(j) : idx_o;
      found_o     = found_o | take_s;
    end
  end

endmodule

// File: rtl/adc_channel_scheduler.sv
// Round-robin ADS1115 single-shot conversion scheduler.
// Optional ADC_SCHED_CLAMP_EN: store negative results as 16'h0000.
module adc_channel_scheduler
  import adc_channel_scheduler_pkg::*;
#(
  parameter int         NUM_CH         = 4,
  parameter int         GAP_CYCLES     = 1_250_000,
  parameter int         TIMEOUT_CYCLES = 2_500_000,
  parameter logic [2:0] PGA            = DEFAULT_PGA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic                 pause,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_cfg_msb,
  output logic [1:0]           cmd_ch,
  input  logic                 rsp_valid,
  input  logic                 rsp_err,
  input  logic [15:0]          rsp_data,
  output logic [16*NUM_CH-1:0] ch_data,
  output logic [NUM_CH-1:0]    ch_valid,
  output logic [7:0]           err_cnt,
  output logic                 busy
);

  // A zero GAP_CYCLES still spends one cycle in GAP.
  localparam logic [31:0] GAP_LAST = (GAP_CYCLES > 1) ? 32'(GAP_CYCLES - 1) : 32'd0;
  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES > 1) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [1:0]  PTR_RST  = 2'(NUM_CH - 1);

  state_e                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [1:0]            ptr_q, ptr_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [1:0]            cmd_ch_q, cmd_ch_d;
  logic [7:0]            cfg_q, cfg_d;
  logic [16*NUM_CH-1:0]  data_q, data_d;
  logic [NUM_CH-1:0]     valid_q, valid_d;
  logic [7:0]            err_q, err_d;
  logic                  busy_q, busy_d;
  logic [1:0]            pick_idx_s;
  logic                  pick_found_s;
  logic [15:0]           rsp_store_s;

  adc_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .mask_i  (ch_en),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx_s),
    .found_o (pick_found_s)
  );

`ifdef ADC_SCHED_CLAMP_EN
  assign rsp_store_s = rsp_data[15] ? 16'h0000 : rsp_data;
`else
  assign rsp_store_s = rsp_data;
`endif

  // Next-state and datapath update; pause is only looked at from IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_ch_d    = cmd_ch_q;
    cfg_d       = cfg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pause) begin
          state_d = ST_PAUSED;
        end else if (pick_found_s) begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_ch_d    = pick_idx_s;
          cfg_d       = cfg_msb(pick_idx_s, PGA);
          ptr_d       = pick_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_d     = ST_WAIT_RSP;
          cmd_valid_d = 1'b0;
          cnt_d       = 32'd0;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_RSP: begin
        // A response arriving on the timeout cycle is taken as the response.
        if (rsp_valid || (cnt_q >= TMO_LAST)) begin
          state_d = ST_GAP;
          cnt_d   = 32'd0;
          if (rsp_valid && !rsp_err) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (cmd_ch_q == 2'(i)) begin
                data_d[16*i +: 16] = rsp_store_s;
                valid_d[i]         = 1'b1;
              end else begin
                data_d[16*i +: 16] = data_q[16*i +: 16];
                valid_d[i]         = valid_q[i];
              end
            end
          end else begin
            for (int i = 0; i < NUM_CH; i++) begin
              valid_d[i] = (cmd_ch_q == 2'(i)) ? 1'b0 : valid_q[i];
            end
            err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          end
        end else begin
          state_d = ST_WAIT_RSP;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q >= GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 32'd0;
        end else begin
          state_d = ST_GAP;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
        cnt_d       = 32'd0;
      end
    endcase
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT_RSP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 32'd0;
      ptr_q       <= PTR_RST;
      cmd_valid_q <= 1'b0;
      cmd_ch_q    <= 2'd0;
      cfg_q       <= 8'd0;
      data_q      <= '0;
      valid_q     <= '0;
      err_q       <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_ch_q    <= cmd_ch_d;
      cfg_q       <= cfg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_ch      = cmd_ch_q;
  assign cmd_cfg_msb = cfg_q;
  assign ch_data     = data_q;
  assign ch_valid    = valid_q;
  assign err_cnt     = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Self-checking bench for adc_channel_scheduler: directed table, timeout,
// pause, randomized traffic against a channel-level model, reset abandonment.
module tb_adc_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int GAP    = 3;
  localparam int TMO    = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ch_en = 4'b0000;
  logic        pause = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic        rsp_err = 1'b0;
  logic [15:0] rsp_data = 16'h0000;
  logic        cmd_valid;
  logic [7:0]  cmd_cfg_msb;
  logic [1:0]  cmd_ch;
  logic [63:0] ch_data;
  logic [3:0]  ch_valid;
  logic [7:0]  err_cnt;
  logic        busy;

  adc_channel_scheduler #(
    .NUM_CH         (NUM_CH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .PGA            (3'b010)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_en       (ch_en),
    .pause       (pause),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_cfg_msb (cmd_cfg_msb),
    .cmd_ch      (cmd_ch),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_data    (rsp_data),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .err_cnt     (err_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Channel-level reference model.
  logic [15:0] m_data [4];
  logic [3:0]  m_valid;
  int          m_err;
  int          m_last;

  typedef struct {
    logic [3:0]  en;
    logic [15:0] data;
    logic        err;
    int          exp_ch;
    logic [7:0]  exp_cfg;
    logic [3:0]  exp_valid;
    logic [7:0]  exp_err;
    logic [15:0] exp_slot;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] store_val(input logic [15:0] d);
`ifdef ADC_SCHED_CLAMP_EN
    return d[15] ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  function automatic int next_ch(input logic [3:0] mask);
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (m_last + k) % NUM_CH;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [63:0] m_pack();
    return {m_data[3], m_data[2], m_data[1], m_data[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: wait for command, delayed accept, delayed response
  // (or none, forcing a timeout), then compare against the model.
  task automatic run_txn(input logic [3:0] mask, input logic [15:0] data, input logic err,
                         input int rdy_dly, input int rsp_dly, input bit no_rsp,
                         input bit pause_wait, output int got_ch, output logic [7:0] got_cfg,
                         output int wait_n);
    int exp_ch;
    int n;
    bit ok;
    ch_en  = mask;
    exp_ch = next_ch(mask);
    n = 0;
    while (!cmd_valid && n < 50) begin
      tick();
      n++;
    end
    wait_n  = n;
    got_ch  = int'(cmd_ch);
    got_cfg = cmd_cfg_msb;
    check("cmd_valid_seen", 64'(cmd_valid), 64'd1);
    check("cmd_ch", 64'(cmd_ch), 64'(exp_ch));
    check("cmd_cfg", 64'(cmd_cfg_msb), 64'(197 + 16 * exp_ch));
    ok = 1'b1;
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      if (!(cmd_valid && (int'(cmd_ch) == exp_ch) && (cmd_cfg_msb == 8'(197 + 16 * exp_ch))))
        ok = 1'b0;
    end
    check("hold_stable", 64'(ok), 64'd1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("busy_in_wait", 64'({busy, cmd_valid}), 64'b10);
    if (pause_wait) pause = 1'b1;
    if (no_rsp) begin
      n = 0;
      while (busy && n < 200) begin
        tick();
        n++;
      end
      check("timeout_len", 64'(n), 64'(TMO));
      m_valid[exp_ch] = 1'b0;
      if (m_err < 255) m_err++;
    end else begin
      for (int i = 0; i < rsp_dly; i++) tick();
      rsp_valid = 1'b1;
      rsp_err   = err;
      rsp_data  = data;
      tick();
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      if (err) begin
        m_valid[exp_ch] = 1'b0;
        if (m_err < 255) m_err++;
      end else begin
        m_data[exp_ch]  = store_val(data);
        m_valid[exp_ch] = 1'b1;
      end
    end
    m_last = exp_ch;
    check("ch_data", ch_data, m_pack());
    check("ch_valid", 64'(ch_valid), 64'(m_valid));
    check("err_cnt", 64'(err_cnt), 64'(m_err));
    if (pause_wait) begin
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (cmd_valid || busy) ok = 1'b0;
      end
      check("paused_hold", 64'(ok), 64'd1);
      pause = 1'b0;
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gc;
    int wn;
    int c0;
    bit ok;
    logic [7:0] gcfg;

    tbl[0] = '{4'b1011, 16'h1234, 1'b0, 0, 8'hC5, 4'b0001, 8'd0, 16'h1234};
    tbl[1] = '{4'b1011, 16'h1234, 1'b0, 1, 8'hD5, 4'b0011, 8'd0, 16'h1234};
    tbl[2] = '{4'b1011, 16'h1234, 1'b0, 3, 8'hF5, 4'b1011, 8'd0, 16'h1234};
    tbl[3] = '{4'b1011, 16'h1234, 1'b0, 0, 8'hC5, 4'b1011, 8'd0, 16'h1234};
    tbl[4] = '{4'b0010, 16'h0100, 1'b0, 1, 8'hD5, 4'b1011, 8'd0, 16'h0100};
    tbl[5] = '{4'b0010, 16'h5555, 1'b1, 1, 8'hD5, 4'b1001, 8'd1, 16'h0100};
    tbl[6] = '{4'b0100, 16'h7FFF, 1'b0, 2, 8'hE5, 4'b1101, 8'd1, 16'h7FFF};
    tbl[7] = '{4'b1111, 16'h3BCD, 1'b0, 3, 8'hF5, 4'b1101, 8'd1, 16'h3BCD};

    for (int i = 0; i < 4; i++) m_data[i] = 16'h0000;
    m_valid = 4'b0000;
    m_err   = 0;
    m_last  = NUM_CH - 1;

    #12;
    check("reset_ctrl", 64'({cmd_valid, cmd_ch, cmd_cfg_msb, busy, err_cnt, ch_valid}), 64'd0);
    check("reset_data", ch_data, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < 8; r++) begin
      run_txn(tbl[r].en, tbl[r].data, tbl[r].err, r % 3, r % 2, 1'b0, 1'b0, gc, gcfg, wn);
      check("tbl_ch", 64'(gc), 64'(tbl[r].exp_ch));
      check("tbl_cfg", 64'(gcfg), 64'(tbl[r].exp_cfg));
      check("tbl_valid", 64'(ch_valid), 64'(tbl[r].exp_valid));
      check("tbl_err", 64'(err_cnt), 64'(tbl[r].exp_err));
      check("tbl_slot", 64'(ch_data[16*tbl[r].exp_ch +: 16]), 64'(tbl[r].exp_slot));
    end

    // Timeout on ch0, then the next channel follows after exactly the gap.
    run_txn(4'b1111, 16'h0000, 1'b0, 0, 0, 1'b1, 1'b0, gc, gcfg, wn);
    check("timeout_ch", 64'(gc), 64'd0);
    run_txn(4'b1111, 16'h2222, 1'b0, 0, 0, 1'b0, 1'b0, gc, gcfg, wn);
    check("after_timeout_ch", 64'(gc), 64'd1);
    check("gap_len", 64'(wn), 64'(GAP + 1));

    // Pause raised mid-transaction: result still lands, then scheduler parks.
    run_txn(4'b0100, 16'h8000, 1'b0, 2, 3, 1'b0, 1'b1, gc, gcfg, wn);
`ifdef ADC_SCHED_CLAMP_EN
    check("pause_capture", 64'(ch_data[47:32]), 64'h0000);
`else
    check("pause_capture", 64'(ch_data[47:32]), 64'h8000);
`endif

    for (int t = 0; t < 40; t++) begin
      run_txn(4'($urandom_range(1, 15)), 16'($urandom), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 5), $urandom_range(0, 20), 1'b0, 1'b0, gc, gcfg, wn);
    end

    for (int t = 0; t < 300; t++) begin
      run_txn(4'b0001, 16'hDEAD, 1'b1, 0, 0, 1'b0, 1'b0, gc, gcfg, wn);
    end
    check("err_saturate", 64'(err_cnt), 64'd255);

    // Command held unaccepted while ch_en drops, then reset mid-WAIT_RSP.
    ch_en = 4'b1111;
    wn = 0;
    while (!cmd_valid && wn < 50) begin
      tick();
      wn++;
    end
    c0 = next_ch(4'b1111);
    ok = cmd_valid;
    for (int i = 0; i < 50; i++) begin
      ch_en = (i % 2 == 0) ? 4'b0000 : 4'b1111;
      tick();
      if (!(cmd_valid && (int'(cmd_ch) == c0) && (cmd_cfg_msb == 8'(197 + 16 * c0)))) ok = 1'b0;
    end
    check("stall_stable", 64'(ok), 64'd1);
    ch_en = 4'b0000;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", 64'({cmd_valid, cmd_ch, cmd_cfg_msb, busy, err_cnt, ch_valid}), 64'd0);
    check("async_reset_data", ch_data, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 16'h4444;
    tick();
    rsp_valid = 1'b0;
    tick();
    check("post_reset_ignore", 64'({ch_valid, err_cnt, busy, cmd_valid}), 64'd0);
    check("post_reset_data", ch_data, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
